// File: rtl/regfile_mm_sequencer_if.sv
// ---------------------------------------------------------------------------
// regfile_mm_sequencer_if
//   Bundle between the operand source, the matrix-multiply sequencer and the
//   level-sensitive product register file.
//
//   Operand side (driven by master, sampled by the sequencer):
//     start, abort       request / cancel a 2x2 by 2x2 multiply
//     a_mat              A[i][k] at bits [(2i+k)*WIDTH +: WIDTH]
//     b_mat              B[k][j] at bits [(2k+j)*WIDTH +: WIDTH]
//   Register-file / status side (driven by the sequencer):
//     product_out        low WIDTH bits of the current partial product
//     reg_specifier      destination register {i,j,k}
//     update_adder_regs  register-file write strobe
//     regfile_reset      register-file clear pulse
//     busy, done         operation in progress / one-cycle completion pulse
//     overflow           sticky: a product needed more than WIDTH bits
// ---------------------------------------------------------------------------
interface regfile_mm_sequencer_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [4*WIDTH-1:0]   a_mat;
    logic [4*WIDTH-1:0]   b_mat;
    logic [WIDTH-1:0]     product_out;
    logic [2:0]           reg_specifier;
    logic                 update_adder_regs;
    logic                 regfile_reset;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    modport master (
        output start, abort, a_mat, b_mat,
        input  product_out, reg_specifier, update_adder_regs, regfile_reset,
               busy, done, overflow
    );

    modport slave (
        input  start, abort, a_mat, b_mat,
        output product_out, reg_specifier, update_adder_regs, regfile_reset,
               busy, done, overflow
    );
endinterface

// File: rtl/regfile_mm_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_mm_sequencer
//   Sequences a 2x2 by 2x2 matrix multiply into the 8-entry product register
//   file. For every index {i,j,k} (k fastest) it forms A[i][k]*B[k][j] and
//   writes it with a setup / strobe / release pattern so that the
//   level-sensitive register file never sees the data or address move while
//   the strobe is high. The downstream adder sums R{i,j,0}+R{i,j,1}.
//
//   Parameters:
//     WIDTH        element / product width
//     HOLD_CYCLES  cycles the write strobe stays high (1..4)
//     CLEAR_FIRST  1: pulse regfile_reset once before the first write
//
//   Ports:
//     i_clk    rising-edge clock
//     i_reset  synchronous, active-high reset (priority over everything)
//     io_seq   slave side of regfile_mm_sequencer_if (see interface header)
//
//   All outputs are registers. They are loaded from the next-state value so
//   each output changes on the same edge as the state it belongs to.
// ---------------------------------------------------------------------------
module regfile_mm_sequencer #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int CLEAR_FIRST = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    regfile_mm_sequencer_if.slave io_seq
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_SETUP   = 3'd2,
        S_WRITE   = 3'd3,
        S_RELEASE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Hold counter counts down from HOLD_CYCLES-1 to 0 while in WRITE.
    localparam logic [1:0] HOLD_LOAD = 2'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_IDX  = 3'd7;

    // Select one WIDTH-bit element of a packed 2x2 matrix; sel = {row, col}.
    function automatic logic [WIDTH-1:0] f_elem(
        input logic [4*WIDTH-1:0] mat,
        input logic [1:0]         sel
    );
        f_elem = mat[int'(sel)*WIDTH +: WIDTH];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [1:0]         r_hold;
    logic [1:0]         w_hold_nxt;
    logic               w_accept;

    logic [4*WIDTH-1:0] r_a_mat;
    logic [4*WIDTH-1:0] r_b_mat;
    logic [4*WIDTH-1:0] w_a_src;
    logic [4*WIDTH-1:0] w_b_src;
    logic [WIDTH-1:0]   w_a_elem;
    logic [WIDTH-1:0]   w_b_elem;
    logic [2*WIDTH-1:0] w_full;
    logic               r_prod_hi_nz;

    logic [WIDTH-1:0]   r_product;
    logic [2:0]         r_reg_spec;
    logic               r_update;
    logic               r_rf_reset;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;

    // Next-state, index and hold-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_hold_nxt  = r_hold;
        w_accept    = 1'b0;
        if (r_state == S_IDLE) begin
            // start wins over a simultaneous abort; abort alone does nothing here
            if (io_seq.start) begin
                w_accept  = 1'b1;
                w_idx_nxt = 3'd0;
                if (CLEAR_FIRST != 0) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else if (io_seq.abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    w_state_nxt = S_SETUP;
                end
                S_SETUP: begin
                    w_state_nxt = S_WRITE;
                    w_hold_nxt  = HOLD_LOAD;
                end
                S_WRITE: begin
                    if (r_hold == 2'd0) begin
                        w_state_nxt = S_RELEASE;
                    end else begin
                        w_hold_nxt = r_hold - 2'd1;
                    end
                end
                S_RELEASE: begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = S_SETUP;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Partial product for the index about to be set up. On the accepting
    // cycle the operands are not yet latched, so read them from the inputs.
    always_comb begin
        if (w_accept) begin
            w_a_src = io_seq.a_mat;
            w_b_src = io_seq.b_mat;
        end else begin
            w_a_src = r_a_mat;
            w_b_src = r_b_mat;
        end
        // idx = {i,j,k}: A element {i,k}, B element {k,j}
        w_a_elem = f_elem(w_a_src, {w_idx_nxt[2], w_idx_nxt[0]});
        w_b_elem = f_elem(w_b_src, {w_idx_nxt[0], w_idx_nxt[1]});
        w_full   = (2*WIDTH)'(w_a_elem) * (2*WIDTH)'(w_b_elem);
    end

    // State, index and hold counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_hold  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Operand latches and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a_mat      <= '0;
            r_b_mat      <= '0;
            r_prod_hi_nz <= 1'b0;
            r_product    <= '0;
            r_reg_spec   <= 3'd0;
            r_update     <= 1'b0;
            r_rf_reset   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_mat <= io_seq.a_mat;
                r_b_mat <= io_seq.b_mat;
            end
            // Address and data move only when entering SETUP, never under the strobe.
            if (w_state_nxt == S_SETUP) begin
                r_reg_spec   <= w_idx_nxt;
                r_product    <= w_full[WIDTH-1:0];
                r_prod_hi_nz <= |w_full[2*WIDTH-1:WIDTH];
            end
            // Overflow accumulates over the products actually written.
            if (w_accept) begin
                r_overflow <= 1'b0;
            end else if ((r_state == S_SETUP) && (w_state_nxt == S_WRITE)) begin
                r_overflow <= r_overflow | r_prod_hi_nz;
            end
            r_update   <= (w_state_nxt == S_WRITE);
            r_rf_reset <= (w_state_nxt == S_CLEAR);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign io_seq.product_out       = r_product;
    assign io_seq.reg_specifier     = r_reg_spec;
    assign io_seq.update_adder_regs = r_update;
    assign io_seq.regfile_reset     = r_rf_reset;
    assign io_seq.busy              = r_busy;
    assign io_seq.done              = r_done;
    assign io_seq.overflow          = r_overflow;

endmodule

// File: tb/tb_regfile_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_mm_sequencer
//   Three sequencer instances: 0 = defaults (CLEAR_FIRST=1, HOLD=1),
//   1 = CLEAR_FIRST=0, 2 = CLEAR_FIRST=0 with HOLD_CYCLES=3.
//   Cycle numbering: the edge that samples start ends cycle 0; cycle n is
//   the interval after edge n-1. A negedge monitor snapshots the active
//   instance each cycle; after each operation the snapshot is compared with
//   the matrix-level expectations (products, write order, timing, flags).
// ---------------------------------------------------------------------------
module tb_regfile_mm_sequencer;
    localparam int WIDTH = 8;
    localparam int N_DUT = 3;
    localparam int SNAP  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_DUT-1:0]   reset_v;
    logic [N_DUT-1:0]   start_v;
    logic [N_DUT-1:0]   abort_v;
    logic [4*WIDTH-1:0] a_v    [N_DUT];
    logic [4*WIDTH-1:0] b_v    [N_DUT];
    logic [WIDTH-1:0]   prod_v [N_DUT];
    logic [2:0]         spec_v [N_DUT];
    logic [N_DUT-1:0]   upd_v;
    logic [N_DUT-1:0]   rfr_v;
    logic [N_DUT-1:0]   busy_v;
    logic [N_DUT-1:0]   done_v;
    logic [N_DUT-1:0]   ovf_v;

    generate
        for (genvar g = 0; g < N_DUT; g++) begin : g_dut
            regfile_mm_sequencer_if #(.WIDTH(WIDTH)) u_if ();
            assign u_if.start = start_v[g];
            assign u_if.abort = abort_v[g];
            assign u_if.a_mat = a_v[g];
            assign u_if.b_mat = b_v[g];
            assign prod_v[g]  = u_if.product_out;
            assign spec_v[g]  = u_if.reg_specifier;
            assign upd_v[g]   = u_if.update_adder_regs;
            assign rfr_v[g]   = u_if.regfile_reset;
            assign busy_v[g]  = u_if.busy;
            assign done_v[g]  = u_if.done;
            assign ovf_v[g]   = u_if.overflow;
            regfile_mm_sequencer #(
                .WIDTH       (WIDTH),
                .HOLD_CYCLES ((g == 2) ? 3 : 1),
                .CLEAR_FIRST ((g == 0) ? 1 : 0)
            ) u_dut (
                .i_clk   (clk),
                .i_reset (reset_v[g]),
                .io_seq  (u_if.slave)
            );
        end
    endgenerate

    int n_cmp = 0;
    int n_err = 0;
    int ncnt  = 0;
    int t0    = 0;
    int act   = 0;
    bit mon_on = 1'b0;

    logic [WIDTH-1:0] s_prod [SNAP];
    logic [2:0]       s_spec [SNAP];
    logic             s_upd  [SNAP];
    logic             s_rfr  [SNAP];
    logic             s_busy [SNAP];
    logic             s_done [SNAP];
    logic             s_ovf  [SNAP];

    // Snapshot the active instance once per cycle, away from the clock edge.
    always @(negedge clk) begin
        ncnt <= ncnt + 1;
        if (mon_on && (ncnt + 1 - t0) >= 1 && (ncnt + 1 - t0) < SNAP) begin
            s_prod[ncnt + 1 - t0] <= prod_v[act];
            s_spec[ncnt + 1 - t0] <= spec_v[act];
            s_upd [ncnt + 1 - t0] <= upd_v[act];
            s_rfr [ncnt + 1 - t0] <= rfr_v[act];
            s_busy[ncnt + 1 - t0] <= busy_v[act];
            s_done[ncnt + 1 - t0] <= done_v[act];
            s_ovf [ncnt + 1 - t0] <= ovf_v[act];
        end
    end

    task automatic check_eq(input string tag, input longint actual, input longint expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int cf_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int h_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    // Cycle in which the strobe for write number n first goes high.
    function automatic int wr_cyc(input int cf, input int h, input int n);
        return 2 + cf + n * (2 + h);
    endfunction

    function automatic int elem(input logic [4*WIDTH-1:0] m, input int r, input int c);
        logic [4*WIDTH-1:0] t;
        t = m >> ((2 * r + c) * WIDTH);
        return int'(t[WIDTH-1:0]);
    endfunction

    function automatic logic [31:0] rand_mat();
        logic [31:0] m;
        m = $urandom;
        if ($urandom_range(0, 1) == 0) m = m & 32'h0F0F0F0F;
        return m;
    endfunction

    // mode: 0 plain, 1 extra starts + a_mat change, 2 abort at write 3,
    //       3 reset at write 5, 4 abort together with start
    task automatic run_op(input string name, input int d, input logic [31:0] a,
                          input logic [31:0] b, input int mode);
        int cf, h, exp_done, end_cyc, cut, n_wr, run_len, full0;
        int exp_prod [8];
        int rf [8];
        int full, wr_cnt, w, hi, got, expv;
        int rise_bad, spec_bad, prod_bad, width_bad, stab_bad, busy_bad;
        int rfr_cnt, rfr_cyc, done_cnt, done_cyc;
        bit exp_ovf, trunc, stops;
        logic prev;
        cf       = cf_of(d);
        h        = h_of(d);
        exp_done = 1 + cf + 8 * (2 + h);
        stops    = (mode == 2) || (mode == 3);
        cut      = (mode == 2) ? 3 : ((mode == 3) ? 5 : 7);
        n_wr     = cut + 1;
        end_cyc  = stops ? wr_cyc(cf, h, cut) : exp_done;
        run_len  = exp_done + 6;
        exp_ovf  = 1'b0;
        full0    = elem(a, 0, 0) * elem(b, 0, 0);
        for (int n = 0; n < 8; n++) begin
            full = elem(a, n / 4, n % 2) * elem(b, n % 2, (n / 2) % 2);
            exp_prod[n] = full % 256;
            if (n <= cut && full > 255) exp_ovf = 1'b1;
            rf[n] = 0;
        end
        if (mode == 3) exp_ovf = 1'b0;

        @(posedge clk); #2;
        act = d; a_v[d] = a; b_v[d] = b; start_v[d] = 1'b1; abort_v[d] = (mode == 4);
        @(posedge clk); #2;
        t0 = ncnt; mon_on = 1'b1; start_v[d] = 1'b0; abort_v[d] = 1'b0;
        for (int c = 1; c <= run_len; c++) begin
            if (mode == 1) begin
                start_v[d] = (c == 10) || (c == exp_done);
                if (c == 12) a_v[d] = ~a;
            end
            if (mode == 2) abort_v[d] = (c == end_cyc);
            if (mode == 3) reset_v[d] = (c == end_cyc);
            @(posedge clk); #2;
        end
        mon_on = 1'b0; start_v[d] = 1'b0; abort_v[d] = 1'b0; reset_v[d] = 1'b0;

        wr_cnt = 0; rise_bad = 0; spec_bad = 0; prod_bad = 0; width_bad = 0;
        stab_bad = 0; busy_bad = 0; rfr_cnt = 0; rfr_cyc = 0; done_cnt = 0; done_cyc = 0;
        prev = 1'b0;
        for (int c = 1; c <= run_len; c++) begin
            if (s_upd[c] && !prev) begin
                w = 0;
                while ((c + w) <= run_len && s_upd[c + w]) w++;
                trunc = stops && (wr_cnt == cut);
                if (wr_cnt < 8) begin
                    if (c != wr_cyc(cf, h, wr_cnt)) rise_bad++;
                    if (int'(s_spec[c]) != wr_cnt) spec_bad++;
                    if (int'(s_prod[c]) != exp_prod[wr_cnt]) prod_bad++;
                    if (w != (trunc ? 1 : h)) width_bad++;
                end
                rf[s_spec[c]] = int'(s_prod[c]);
                hi = trunc ? (c + w - 1) : (c + w);
                for (int x = c - 1; x <= hi && x <= run_len; x++) begin
                    if (s_spec[x] != s_spec[c] || s_prod[x] != s_prod[c]) stab_bad++;
                end
                wr_cnt++;
            end
            prev = s_upd[c];
            if (s_busy[c] != (c <= end_cyc)) busy_bad++;
            if (s_rfr[c]) begin
                if (rfr_cnt == 0) rfr_cyc = c;
                rfr_cnt++;
            end
            if (s_done[c]) begin
                if (done_cnt == 0) done_cyc = c;
                done_cnt++;
            end
        end

        check_eq({name, " writes"}, wr_cnt, n_wr);
        check_eq({name, " strobe_cycle_errs"}, rise_bad, 0);
        check_eq({name, " specifier_errs"}, spec_bad, 0);
        check_eq({name, " product_errs"}, prod_bad, 0);
        check_eq({name, " width_errs"}, width_bad, 0);
        check_eq({name, " stability_errs"}, stab_bad, 0);
        check_eq({name, " busy_errs"}, busy_bad, 0);
        check_eq({name, " regfile_reset_cycles"}, rfr_cnt, cf);
        if (rfr_cnt > 0) check_eq({name, " regfile_reset_at"}, rfr_cyc, 1);
        check_eq({name, " done_cycles"}, done_cnt, stops ? 0 : 1);
        if (done_cnt > 0) check_eq({name, " done_at"}, done_cyc, exp_done);
        check_eq({name, " ovf_cleared"}, s_ovf[1], 0);
        check_eq({name, " ovf_first_write"}, s_ovf[wr_cyc(cf, h, 0) + h], (full0 > 255) ? 1 : 0);
        check_eq({name, " ovf_end"}, s_ovf[run_len], exp_ovf);
        if (!stops) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    got  = (rf[i * 4 + j * 2] + rf[i * 4 + j * 2 + 1]) % 256;
                    expv = (elem(a, i, 0) * elem(b, 0, j) + elem(a, i, 1) * elem(b, 1, j)) % 256;
                    check_eq($sformatf("%s sum_c%0d%0d", name, i, j), got, expv);
                end
            end
        end
        if (mode == 2) check_eq({name, " strobe_after_abort"}, s_upd[end_cyc + 1], 0);
        if (mode == 3) begin
            check_eq({name, " rst_spec"},  s_spec[end_cyc + 1], 0);
            check_eq({name, " rst_prod"},  s_prod[end_cyc + 1], 0);
            check_eq({name, " rst_upd"},   s_upd[end_cyc + 1], 0);
            check_eq({name, " rst_rfr"},   s_rfr[end_cyc + 1], 0);
            check_eq({name, " rst_busy"},  s_busy[end_cyc + 1], 0);
            check_eq({name, " rst_done"},  s_done[end_cyc + 1], 0);
            check_eq({name, " rst_ovf"},   s_ovf[end_cyc + 1], 0);
        end
    endtask

    initial begin
        reset_v = '1;
        start_v = '0;
        abort_v = '0;
        for (int d = 0; d < N_DUT; d++) begin
            a_v[d] = '0;
            b_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < N_DUT; d++) begin
            check_eq($sformatf("reset%0d prod", d), prod_v[d], 0);
            check_eq($sformatf("reset%0d spec", d), spec_v[d], 0);
            check_eq($sformatf("reset%0d upd",  d), upd_v[d], 0);
            check_eq($sformatf("reset%0d rfr",  d), rfr_v[d], 0);
            check_eq($sformatf("reset%0d busy", d), busy_v[d], 0);
            check_eq($sformatf("reset%0d done", d), done_v[d], 0);
            check_eq($sformatf("reset%0d ovf",  d), ovf_v[d], 0);
        end
        reset_v = '0;

        // abort alone in IDLE must not start anything
        @(posedge clk); #2;
        abort_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        abort_v[0] = 1'b0;
        check_eq("idle_abort busy", busy_v[0], 0);
        check_eq("idle_abort upd", upd_v[0], 0);

        run_op("ident",      0, 32'h01000001, 32'h04030201, 0);
        run_op("ovf",        0, 32'h10101010, 32'h20202020, 0);
        run_op("ovf_clear",  0, 32'h01020304, 32'h05060708, 0);
        run_op("hold3",      2, 32'h0A0B0C0D, 32'h01020304, 0);
        run_op("noclear",    1, 32'h11223344, 32'h55667788, 0);
        run_op("ignore",     0, 32'h03050709, 32'h02040608, 1);
        run_op("abort",      0, 32'hF0E0D0C0, 32'h0F0E0D0C, 2);
        run_op("post_abort", 0, 32'h01010101, 32'h02020202, 0);
        run_op("rst_mid",    0, 32'h09080706, 32'h05040302, 3);
        run_op("post_rst",   0, 32'h0C0B0A09, 32'h08070605, 0);
        run_op("rst_nocl",   1, 32'h21324354, 32'h65768798, 3);
        run_op("start_abrt", 0, 32'h01000001, 32'hAABBCCDD, 4);

        for (int r = 0; r < 10; r++) begin
            run_op($sformatf("rnd%0d", r), $urandom_range(0, N_DUT - 1),
                   rand_mat(), rand_mat(), $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_mm_sequencer.md
Name: regfile_mm_sequencer

Overview:
- Controller that sequences a 2x2 by 2x2 matrix multiply into the 8-entry, 8-bit product register file.
- Latches both operand matrices and forms the 8 partial products A[i][k]*B[k][j] in an internal multiplier.
- Writes each product into register {i,j,k} with a clean setup/strobe/release pulse, because the register file is level-sensitive.
- Sits between the operand source and the register file; the downstream adder sums R{i,j,0}+R{i,j,1}.

Parameters:
- WIDTH, 8, element and product width; matches the register-file entry width.
- HOLD_CYCLES, 1, cycles update_adder_regs stays high per write (1..4).
- CLEAR_FIRST, 1, when 1, pulse regfile_reset for one cycle before the first write.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- abort  in  1  cancel the operation in progress; sampled every cycle.
- a_mat  in  4*WIDTH  A[i][k] at bits [(2i+k)*WIDTH +: WIDTH].
- b_mat  in  4*WIDTH  B[k][j] at bits [(2k+j)*WIDTH +: WIDTH].
- product_out  out  WIDTH  to register-file product_in.
- reg_specifier  out  3  register index {i,j,k}: i is the MSB, k is the LSB.
- update_adder_regs  out  1  register-file write strobe.
- regfile_reset  out  1  register-file clear pulse.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: some product exceeded WIDTH bits during the current or last operation.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; product_out=0; reg_specifier=0; update_adder_regs=0; regfile_reset=0; busy=0; done=0; overflow=0; index counter=0.
- Reset has priority over every other input and takes effect at the next edge, including mid-operation. No further strobes are issued after reset.
- States:
  - IDLE -> (start) CLEAR if CLEAR_FIRST=1, else SETUP.
  - CLEAR: regfile_reset=1 for exactly one cycle -> SETUP.
  - SETUP: drive reg_specifier=idx and product_out=low WIDTH bits of A[i][k]*B[k][j]; strobe low -> WRITE.
  - WRITE: update_adder_regs=1 for HOLD_CYCLES cycles; specifier and product held -> RELEASE.
  - RELEASE: strobe low; specifier and product still held. If idx==7 go to DONE, else idx+1 and go to SETUP.
  - DONE: done=1 for one cycle -> IDLE.
- At start acceptance:
  - a_mat and b_mat are latched; later input changes are ignored until the next start.
  - overflow is cleared.
  - idx is set to 0.
- Arithmetic:
  - Unsigned 2*WIDTH-bit product; product_out takes bits [WIDTH-1:0].
  - overflow is set when bits [2*WIDTH-1:WIDTH] are nonzero for any product.
- reg_specifier and product_out change only when entering SETUP. They are never changed while the strobe is high.
- Index order is 0..7; idx is {i,j,k} with k varying fastest. No wrap past 7.
- start is ignored outside IDLE, including during the DONE cycle. A start asserted in the DONE cycle is not queued.
- abort (non-IDLE, no reset):
  - Next state is IDLE and update_adder_regs=0 at the next edge.
  - busy drops; no done pulse; overflow holds its value.
  - Registers already written keep their values.
  - abort in IDLE has no effect. If start and abort are high together in IDLE, start wins.
- Latency, with the start edge as cycle 0 and HOLD_CYCLES=H:
  - done is high in cycle 1+CLEAR_FIRST+8*(2+H).
  - Defaults give cycle 26; CLEAR_FIRST=0 gives cycle 25.
- busy is high in cycles 1 through the DONE cycle inclusive.

Test Plan:
- Identity A (a_mat=0x01000001), B=0x04030201, defaults -> regfile_reset pulse in cycle 1. Write sequence by register index 0..7: 1,0,2,0,0,3,0,4. done in cycle 26; overflow=0; sums give C=B.
- A elements all 0x10, B elements all 0x20 -> every product_out=0x00, overflow=1 after the first WRITE and still 1 after done. A following start clears overflow.
- Check strobe timing: update_adder_regs goes high exactly 8 times, each 1 cycle wide. reg_specifier and product_out are stable from SETUP through RELEASE. With HOLD_CYCLES=3, each pulse is 3 cycles and done is in cycle 41.
- Pulse start again at cycle 10 and again in the DONE cycle -> both ignored; exactly 8 writes and one done. Changing a_mat mid-operation does not alter any product.
- Assert abort during the WRITE of idx=3 -> strobe low next cycle, state IDLE, busy=0, no done. A new start then runs a full 8-write sequence.
- Assert reset during idx=5 -> all outputs at reset values next cycle and no further strobes. With CLEAR_FIRST=0, no regfile_reset pulse and done in cycle 25.
